pht_access_ctrl: RTL

//  Arbiter/sequencer for the single-address-port pre-set pattern history table.

---
 rtl/pht_pkg.sv | 46 ++++
 rtl/pht_upd_fifo.sv | 90 +++++++++
 rtl/pht_access_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pht_pkg.sv
// Shared definitions for the pattern-history-table access controller:
// widths, counter limits, saturating update rule and sequencer states.
package pht_pkg;

    localparam int SET_W  = 2;
    localparam int TAB_W  = 8;
    localparam int DATA_W = 2;
    localparam int ADDR_W = SET_W + TAB_W;
    localparam int ENT_W  = SET_W + TAB_W + 1;

    localparam logic [DATA_W-1:0] CNT_MAX  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] CNT_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } pht_state_e;

    typedef struct packed {
        logic [SET_W-1:0] set;
        logic [TAB_W-1:0] idx;
        logic             taken;
    } upd_entry_t;

    // Two-way saturating counter step; never wraps at either end.
    function automatic logic [DATA_W-1:0] sat_update(input logic [DATA_W-1:0] cnt,
                                                     input logic              taken);
        logic [DATA_W-1:0] res;
        if (taken) begin
            if (cnt == CNT_MAX) begin
                res = CNT_MAX;
            end else begin
                res = cnt + DATA_W'(1);
            end
        end else begin
            if (cnt == CNT_ZERO) begin
                res = CNT_ZERO;
            end else begin
                res = cnt - DATA_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Circular queue of pending counter updates. Every slot's address and
// occupancy is exported so a lookup can tell whether a write is still pending.
module pht_upd_fifo
    import pht_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ENT_W-1:0]        push_data,
    input  logic                    pop,
    output logic [ENT_W-1:0]        head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DEPTH*ADDR_W-1:0] ent_addr,
    output logic [DEPTH-1:0]        ent_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    upd_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_nxt_s;
    logic             push_s;
    logic             pop_s;

    // Full blocks a push even when the head drains in the same cycle.
    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == (PTR_W+1)'(0));
    assign push_s    = push & ~full;
    assign pop_s     = pop & ~empty;
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign ent_valid = valid_r;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_addr[g*ADDR_W +: ADDR_W] = {mem_r[g].idx, mem_r[g].set};
    end

    // Per-slot occupancy after this cycle's pop and push.
    always_comb begin
        valid_nxt_s = valid_r;
        if (pop_s) begin
            valid_nxt_s[rd_ptr_r] = 1'b0;
        end else begin
            valid_nxt_s[rd_ptr_r] = valid_r[rd_ptr_r];
        end
        if (push_s) begin
            valid_nxt_s[wr_ptr_r] = 1'b1;
        end else begin
            valid_nxt_s[wr_ptr_r] = valid_nxt_s[wr_ptr_r];
        end
    end

    // Pointer, count and occupancy registers; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
            valid_r <= valid_nxt_s;
        end
    end

    // Entry payload storage; needs no reset because occupancy guards it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= upd_entry_t'(push_data);
        end
    end

endmodule

// File: rtl/pht_access_ctrl.sv
// Shares the single-port pattern history table between fetch lookups and
// retire-stage read-modify-write counter updates, with anti-starvation.
module pht_access_ctrl
    import pht_pkg::*;
#(
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [SET_W-1:0]  lk_set,
    input  logic [TAB_W-1:0]  lk_idx,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_cnt,
    output logic              rsp_taken,
    output logic              rsp_stale,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [SET_W-1:0]  upd_set,
    input  logic [TAB_W-1:0]  upd_idx,
    input  logic              upd_taken,
    output logic              tab_wr_en,
    output logic [DATA_W-1:0] tab_up_data,
    output logic [SET_W-1:0]  tab_set_addr,
    output logic [TAB_W-1:0]  tab_tab_addr,
    input  logic [DATA_W-1:0] tab_rd_data
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX) + 1;

    pht_state_e              state_r;
    pht_state_e              state_nxt_s;
    logic [STV_W-1:0]        starve_r;
    logic [STV_W-1:0]        starve_nxt_s;
    logic                    lk_ready_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    lk_own_s;
    logic                    head_own_s;
    logic                    stale_hit_s;
    logic                    last_drain_s;
    logic [ENT_W-1:0]        fifo_head_s;
    upd_entry_t              head_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CNT_W-1:0]        fifo_count_s;
    logic [QDEPTH*ADDR_W-1:0] fifo_addr_s;
    logic [QDEPTH-1:0]       fifo_valid_s;
    logic                    rsp_valid_r;
    logic [DATA_W-1:0]       rsp_cnt_r;
    logic                    rsp_stale_r;

    assign push_s     = upd_valid & ~fifo_full_s;
    assign upd_ready  = ~fifo_full_s;
    assign head_s     = upd_entry_t'(fifo_head_s);
    assign lk_ready   = lk_ready_s;
    assign lk_own_s   = lk_valid & lk_ready_s;
    assign head_own_s = pop_s & ~fifo_empty_s;
    // Queue empties this cycle only if the drained head was the sole entry and nothing arrives.
    assign last_drain_s = (fifo_count_s == CNT_W'(1)) & ~push_s;

    pht_upd_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({upd_set, upd_idx, upd_taken}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .ent_addr  (fifo_addr_s),
        .ent_valid (fifo_valid_s)
    );

    // Sequencer next state: lookups win until the head has waited STARVE_MAX cycles.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_r;
        lk_ready_s   = 1'b1;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (push_s) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (fifo_empty_s) begin
                    state_nxt_s  = ST_IDLE;
                    starve_nxt_s = {STV_W{1'b0}};
                end else if (lk_valid) begin
                    starve_nxt_s = starve_r + STV_W'(1);
                    if (starve_r == STV_W'(STARVE_MAX - 1)) begin
                        state_nxt_s = ST_FORCE;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end else begin
                    pop_s        = 1'b1;
                    starve_nxt_s = {STV_W{1'b0}};
                    if (last_drain_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end
            end
            ST_FORCE: begin
                lk_ready_s   = 1'b0;
                pop_s        = 1'b1;
                starve_nxt_s = {STV_W{1'b0}};
                if (last_drain_s || fifo_empty_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                starve_nxt_s = {STV_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and starvation counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            starve_r <= {STV_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end

    // Table port mux: head does its RMW in one cycle, write lands at the edge.
    always_comb begin
        tab_wr_en    = 1'b0;
        tab_up_data  = {DATA_W{1'b0}};
        tab_set_addr = {SET_W{1'b0}};
        tab_tab_addr = {TAB_W{1'b0}};
        if (head_own_s) begin
            tab_wr_en    = ~reset;
            tab_up_data  = sat_update(tab_rd_data, head_s.taken);
            tab_set_addr = head_s.set;
            tab_tab_addr = head_s.idx;
        end else if (lk_own_s) begin
            tab_set_addr = lk_set;
            tab_tab_addr = lk_idx;
        end else begin
            tab_wr_en = 1'b0;
        end
    end

    // A lookup is stale if any occupied queue slot targets the same table entry.
    always_comb begin
        stale_hit_s = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (fifo_valid_s[i] && (fifo_addr_s[i*ADDR_W +: ADDR_W] == {lk_idx, lk_set})) begin
                stale_hit_s = 1'b1;
            end else begin
                stale_hit_s = stale_hit_s;
            end
        end
    end

    // Registered lookup response; count and stale flag hold between accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_cnt_r   <= {DATA_W{1'b0}};
            rsp_stale_r <= 1'b0;
        end else if (lk_own_s) begin
            rsp_valid_r <= 1'b1;
            rsp_cnt_r   <= tab_rd_data;
            rsp_stale_r <= stale_hit_s;
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_cnt   = rsp_cnt_r;
    assign rsp_taken = rsp_cnt_r[DATA_W-1];
    assign rsp_stale = rsp_stale_r;

endmodule
